// File: rtl/minisrc_datapath.sv
// MiniSRC 32-bit datapath: program counter, 16x32 register file, ALU with
// operand and result latches, write-back register and memory address/data
// paths. The external control unit drives every enable and select each cycle.
// Optional feature macro: DATAPATH_DIV_EN (signed divider for opcode 10;
// without it opcode 10 returns zero in both result words).
module minisrc_datapath (
    input  logic        iClk,
    input  logic        nRst,
    input  logic [31:0] iMemData,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemData,
    input  logic        iPC_nRst,
    input  logic        iPC_en,
    input  logic        iPC_jmp,
    input  logic        iPC_loadRA,
    input  logic        iPC_loadImm,
    input  logic        iRF_Write,
    input  logic [3:0]  iRF_AddrA,
    input  logic [3:0]  iRF_AddrB,
    input  logic [3:0]  iRF_AddrC,
    input  logic        iRWB_en,
    input  logic [3:0]  iALU_Ctrl,
    input  logic        iRA_en,
    input  logic        iRB_en,
    input  logic        iRZH_en,
    input  logic        iRZL_en,
    input  logic        iRAS_en,
    output logic        oJ_zero,
    output logic        oJ_nZero,
    output logic        oJ_pos,
    output logic        oJ_neg,
    output logic        oALU_neg,
    output logic        oALU_zero,
    input  logic        iMUX_BIS,
    input  logic        iMUX_RZHS,
    input  logic        iMUX_WBM,
    input  logic        iMUX_WBP,
    input  logic        iMUX_MAP,
    input  logic        iMUX_ASS,
    input  logic [31:0] iImm32
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHRA = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_NEG  = 4'd11;
    localparam logic [3:0] OP_NOT  = 4'd12;
    localparam logic [3:0] OP_PASB = 4'd13;

    logic [31:0] pc;
    logic [31:0] rf [16];
    logic [31:0] ra, rb, rzh, rzl, ras, rwb;
    logic [31:0] port_a, port_b, zout;
    logic [31:0] alu_hi, alu_lo;
    logic [63:0] rot, prod;
    logic [4:0]  sh;

    assign port_a = rf[iRF_AddrA];
    assign port_b = rf[iRF_AddrB];
    assign sh     = rb[4:0];
    assign zout   = iMUX_RZHS ? rzh : rzl;

`ifdef DATAPATH_DIV_EN
    logic [31:0] div_q, div_r;
    // Signed quotient/remainder, truncating toward zero; the zero-divisor
    // case is overridden in the ALU mux below.
    assign div_q = $signed(ra) / $signed(rb);
    assign div_r = $signed(ra) % $signed(rb);
`endif

    // Program counter: sync clear beats jump-to-RA beats relative branch beats increment.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst)
            pc <= '0;
        else if (!iPC_nRst)
            pc <= '0;
        else if (iPC_en && iPC_loadRA)
            pc <= ra;
        else if (iPC_en && iPC_loadImm && iPC_jmp)
            pc <= pc + 32'd1 + iImm32;
        else if (iPC_en)
            pc <= pc + 32'd1;
    end

    // Register file write port C; reads are combinational so same-cycle reads see the old value.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < 16; i++)
                rf[i] <= '0;
        end else if (iRF_Write) begin
            rf[iRF_AddrC] <= rwb;
        end
    end

    // Operand, result, store and write-back latches.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            ra  <= '0;
            rb  <= '0;
            rzh <= '0;
            rzl <= '0;
            ras <= '0;
            rwb <= '0;
        end else begin
            if (iRA_en)  ra  <= port_a;
            if (iRB_en)  rb  <= iMUX_BIS ? iImm32 : port_b;
            if (iRZH_en) rzh <= alu_hi;
            if (iRZL_en) rzl <= alu_lo;
            if (iRAS_en) ras <= iMUX_ASS ? zout : port_b;
            if (iRWB_en) begin
                if (iMUX_WBM)
                    rwb <= iMemData;
                else if (iMUX_WBP)
                    rwb <= pc;
                else
                    rwb <= zout;
            end
        end
    end

    // ALU: 64-bit {hi,lo} result; hi is only used by MUL and DIV.
    always_comb begin
        alu_hi = '0;
        alu_lo = '0;
        rot    = '0;
        prod   = '0;
        case (iALU_Ctrl)
            OP_ADD:  alu_lo = ra + rb;
            OP_SUB:  alu_lo = ra - rb;
            OP_AND:  alu_lo = ra & rb;
            OP_OR:   alu_lo = ra | rb;
            OP_SHR:  alu_lo = ra >> sh;
            OP_SHRA: alu_lo = $signed(ra) >>> sh;
            OP_SHL:  alu_lo = ra << sh;
            OP_ROR: begin
                rot    = {ra, ra} >> sh;
                alu_lo = rot[31:0];
            end
            OP_ROL: begin
                rot    = {ra, ra} << sh;
                alu_lo = rot[63:32];
            end
            OP_MUL: begin
                // Low 64 bits of the product of sign-extended operands equal the signed product.
                prod   = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
                alu_hi = prod[63:32];
                alu_lo = prod[31:0];
            end
            OP_DIV: begin
`ifdef DATAPATH_DIV_EN
                if (rb == 32'd0) begin
                    alu_lo = 32'hFFFF_FFFF;
                    alu_hi = ra;
                end else begin
                    alu_lo = div_q;
                    alu_hi = div_r;
                end
`else
                alu_lo = '0;
                alu_hi = '0;
`endif
            end
            OP_NEG:  alu_lo = -ra;
            OP_NOT:  alu_lo = ~ra;
            OP_PASB: alu_lo = rb;
            default: alu_lo = '0;
        endcase
    end

    // Flags and memory-side outputs.
    always_comb begin
        oALU_zero = (alu_lo == 32'd0);
        oALU_neg  = alu_lo[31];
        oJ_zero   = (ra == 32'd0);
        oJ_nZero  = (ra != 32'd0);
        oJ_pos    = ~ra[31] & (ra != 32'd0);
        oJ_neg    = ra[31];
        oMemAddr  = iMUX_MAP ? pc : rzl;
        oMemData  = ras;
    end

endmodule

// File: tb/tb_minisrc_datapath.sv
// Self-checking bench for minisrc_datapath: ALU vector table plus
// hand-written sequences for load, NEG, fetch/branch, write-back priority
// and asynchronous reset. Expected values go through a scoreboard queue.
module tb_minisrc_datapath;

    logic        iClk = 1'b0;
    logic        nRst;
    logic [31:0] iMemData, oMemAddr, oMemData, iImm32;
    logic        iPC_nRst, iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm;
    logic        iRF_Write, iRWB_en;
    logic [3:0]  iRF_AddrA, iRF_AddrB, iRF_AddrC, iALU_Ctrl;
    logic        iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en;
    logic        oJ_zero, oJ_nZero, oJ_pos, oJ_neg, oALU_neg, oALU_zero;
    logic        iMUX_BIS, iMUX_RZHS, iMUX_WBM, iMUX_WBP, iMUX_MAP, iMUX_ASS;

    minisrc_datapath dut (
        .iClk(iClk), .nRst(nRst), .iMemData(iMemData), .oMemAddr(oMemAddr),
        .oMemData(oMemData), .iPC_nRst(iPC_nRst), .iPC_en(iPC_en),
        .iPC_jmp(iPC_jmp), .iPC_loadRA(iPC_loadRA), .iPC_loadImm(iPC_loadImm),
        .iRF_Write(iRF_Write), .iRF_AddrA(iRF_AddrA), .iRF_AddrB(iRF_AddrB),
        .iRF_AddrC(iRF_AddrC), .iRWB_en(iRWB_en), .iALU_Ctrl(iALU_Ctrl),
        .iRA_en(iRA_en), .iRB_en(iRB_en), .iRZH_en(iRZH_en), .iRZL_en(iRZL_en),
        .iRAS_en(iRAS_en), .oJ_zero(oJ_zero), .oJ_nZero(oJ_nZero),
        .oJ_pos(oJ_pos), .oJ_neg(oJ_neg), .oALU_neg(oALU_neg),
        .oALU_zero(oALU_zero), .iMUX_BIS(iMUX_BIS), .iMUX_RZHS(iMUX_RZHS),
        .iMUX_WBM(iMUX_WBM), .iMUX_WBP(iMUX_WBP), .iMUX_MAP(iMUX_MAP),
        .iMUX_ASS(iMUX_ASS), .iImm32(iImm32)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic idle();
        iMemData = '0; iImm32 = '0;
        iPC_nRst = 1'b1; iPC_en = 1'b0; iPC_jmp = 1'b0;
        iPC_loadRA = 1'b0; iPC_loadImm = 1'b0;
        iRF_Write = 1'b0; iRWB_en = 1'b0;
        iRF_AddrA = '0; iRF_AddrB = '0; iRF_AddrC = '0; iALU_Ctrl = '0;
        iRA_en = 1'b0; iRB_en = 1'b0; iRZH_en = 1'b0; iRZL_en = 1'b0; iRAS_en = 1'b0;
        iMUX_BIS = 1'b0; iMUX_RZHS = 1'b0; iMUX_WBM = 1'b0;
        iMUX_WBP = 1'b0; iMUX_MAP = 1'b0; iMUX_ASS = 1'b0;
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
        idle();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] act);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_underflow: got %08h want <nothing queued>", act);
        end else begin
            e = sb_q.pop_front();
            chk(e.name, act, e.val);
        end
    endtask

    task automatic load_reg(input logic [3:0] r, input logic [31:0] v);
        iMemData = v; iMUX_WBM = 1'b1; iRWB_en = 1'b1;
        tick();
        iRF_Write = 1'b1; iRF_AddrC = r;
        tick();
    endtask

    // Register contents are only observable via port B -> RAS -> oMemData.
    task automatic read_reg(input logic [3:0] r, output logic [31:0] v);
        iRF_AddrB = r; iRAS_en = 1'b1;
        tick();
        v = oMemData;
    endtask

    task automatic read_pc(output logic [31:0] v);
        iMUX_MAP = 1'b1;
        #1;
        v = oMemAddr;
        iMUX_MAP = 1'b0;
        #1;
    endtask

    task automatic add_vec(input string n, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] flags_exp;

        add_vec("add",       4'd0,  32'd5,         32'd7,         32'd0,         32'd12);
        add_vec("add_wrap",  4'd0,  32'hFFFFFFFF,  32'd1,         32'd0,         32'd0);
        add_vec("sub",       4'd1,  32'd3,         32'd5,         32'd0,         32'hFFFFFFFE);
        add_vec("and",       4'd2,  32'h0000F0F0,  32'h0000FF00,  32'd0,         32'h0000F000);
        add_vec("or",        4'd3,  32'h0000F0F0,  32'h0000FF00,  32'd0,         32'h0000FFF0);
        add_vec("shr",       4'd4,  32'h80000000,  32'd4,         32'd0,         32'h08000000);
        add_vec("shra",      4'd5,  32'h80000000,  32'd4,         32'd0,         32'hF8000000);
        add_vec("shl31",     4'd6,  32'd1,         32'd31,        32'd0,         32'h80000000);
        add_vec("shl_amt5",  4'd6,  32'd1,         32'd33,        32'd0,         32'd2);
        add_vec("ror",       4'd7,  32'd1,         32'd1,         32'd0,         32'h80000000);
        add_vec("ror0",      4'd7,  32'h12345678,  32'd0,         32'd0,         32'h12345678);
        add_vec("rol",       4'd8,  32'h80000000,  32'd1,         32'd0,         32'd1);
        add_vec("mul_neg",   4'd9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  32'hFFFFFFFA);
        add_vec("mul_big",   4'd9,  32'h00010000,  32'h00010000,  32'd1,         32'd0);
`ifdef DATAPATH_DIV_EN
        add_vec("div",       4'd10, 32'd7,         32'd2,         32'd1,         32'd3);
        add_vec("div_zero",  4'd10, 32'd7,         32'd0,         32'd7,         32'hFFFFFFFF);
        add_vec("div_neg",   4'd10, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFD);
`else
        add_vec("div_off",   4'd10, 32'd7,         32'd2,         32'd0,         32'd0);
        add_vec("div0_off",  4'd10, 32'd7,         32'd0,         32'd0,         32'd0);
`endif
        add_vec("neg",       4'd11, 32'd5,         32'd0,         32'd0,         32'hFFFFFFFB);
        add_vec("not",       4'd12, 32'd0,         32'd0,         32'd0,         32'hFFFFFFFF);
        add_vec("passb",     4'd13, 32'd9,         32'h00001234,  32'd0,         32'h00001234);
        add_vec("op14",      4'd14, 32'd9,         32'd9,         32'd0,         32'd0);
        add_vec("op15",      4'd15, 32'd9,         32'd9,         32'd0,         32'd0);

        idle();
        nRst = 1'b0;
        #12;
        // Reset state
        chk("rst_rzl", oMemAddr, 32'd0);
        chk("rst_ras", oMemData, 32'd0);
        chk("rst_jzero", {31'd0, oJ_zero}, 32'd1);
        chk("rst_aluzero", {31'd0, oALU_zero}, 32'd1);
        @(negedge iClk);
        nRst = 1'b1;
        #1;

        // Fetch and PC priority
        iPC_en = 1'b1; iMUX_MAP = 1'b1;
        #1;
        chk("fetch_addr_pre", oMemAddr, 32'd0);
        tick();
        read_pc(v); chk("pc_inc", v, 32'd1);
        iPC_en = 1'b1; iPC_loadImm = 1'b1; iPC_jmp = 1'b1; iImm32 = 32'd4;
        tick();
        read_pc(v); chk("pc_branch", v, 32'd6);
        iPC_en = 1'b1; iPC_loadImm = 1'b1; iImm32 = 32'd4;
        tick();
        read_pc(v); chk("pc_not_taken", v, 32'd7);
        iPC_loadRA = 1'b1; iPC_loadImm = 1'b1; iPC_jmp = 1'b1;
        tick();
        read_pc(v); chk("pc_hold", v, 32'd7);
        iPC_nRst = 1'b0; iPC_en = 1'b1;
        tick();
        read_pc(v); chk("pc_sync_clr", v, 32'd0);

        // Register loads from memory
        load_reg(4'd5, 32'h22);
        load_reg(4'd7, 32'h24);
        load_reg(4'd4, 32'h28);
        sb_push("r5_load", 32'h22); read_reg(4'd5, v); sb_check(v);
        sb_push("r7_load", 32'h24); read_reg(4'd7, v); sb_check(v);
        sb_push("r4_load", 32'h28); read_reg(4'd4, v); sb_check(v);

        // NEG R5 through the full four-edge path
        iRF_AddrA = 4'd5; iRA_en = 1'b1;
        tick();
        iALU_Ctrl = 4'd11;
        #1;
        chk("neg_flag", {31'd0, oALU_neg}, 32'd1);
        iRZL_en = 1'b1;
        tick();
        iRWB_en = 1'b1;
        tick();
        // Write R5 while sampling R5 on port B in the same edge: must see the old value.
        iRF_Write = 1'b1; iRF_AddrC = 4'd5; iRF_AddrB = 4'd5; iRAS_en = 1'b1;
        sb_push("rf_read_old", 32'h22);
        tick();
        sb_check(oMemData);
        sb_push("r5_neg", 32'hFFFFFFDE); read_reg(4'd5, v); sb_check(v);

        // PC from RA (RA=0x22) wins over a relative branch
        iPC_en = 1'b1; iPC_loadRA = 1'b1; iPC_loadImm = 1'b1; iPC_jmp = 1'b1; iImm32 = 32'd100;
        tick();
        read_pc(v); chk("pc_load_ra", v, 32'h22);
        // Write-back select priority: PC path, then memory over PC
        iMUX_WBP = 1'b1; iRWB_en = 1'b1;
        tick();
        iRF_Write = 1'b1; iRF_AddrC = 4'd9;
        tick();
        sb_push("wb_pc", 32'h22); read_reg(4'd9, v); sb_check(v);
        iMUX_WBP = 1'b1; iMUX_WBM = 1'b1; iMemData = 32'h99; iRWB_en = 1'b1;
        tick();
        iRF_Write = 1'b1; iRF_AddrC = 4'd9;
        tick();
        sb_push("wb_mem_prio", 32'h99); read_reg(4'd9, v); sb_check(v);

        // ALU vector table
        foreach (tbl[i]) begin
            load_reg(4'd1, tbl[i].a);
            iRF_AddrA = 4'd1; iRA_en = 1'b1;
            iMUX_BIS = 1'b1; iImm32 = tbl[i].b; iRB_en = 1'b1;
            tick();
            iALU_Ctrl = tbl[i].op;
            #1;
            flags_exp = {26'd0, tbl[i].a[31], ~tbl[i].a[31] & (tbl[i].a != 0),
                         tbl[i].a != 0, tbl[i].a == 0, tbl[i].lo[31], tbl[i].lo == 0};
            chk({tbl[i].name, "_flags"},
                {26'd0, oJ_neg, oJ_pos, oJ_nZero, oJ_zero, oALU_neg, oALU_zero}, flags_exp);
            iRZH_en = 1'b1; iRZL_en = 1'b1;
            sb_push({tbl[i].name, "_lo"}, tbl[i].lo);
            sb_push({tbl[i].name, "_hi"}, tbl[i].hi);
            tick();
            sb_check(oMemAddr);
            iMUX_RZHS = 1'b1; iMUX_ASS = 1'b1; iRAS_en = 1'b1;
            tick();
            sb_check(oMemData);
        end

        // Asynchronous reset mid-operation: RZL=5, PC=3
        load_reg(4'd1, 32'd2);
        iRF_AddrA = 4'd1; iRA_en = 1'b1; iMUX_BIS = 1'b1; iImm32 = 32'd3; iRB_en = 1'b1;
        tick();
        iALU_Ctrl = 4'd0; iRZL_en = 1'b1;
        tick();
        chk("pre_rst_rzl", oMemAddr, 32'd5);
        iPC_nRst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            iPC_en = 1'b1;
            tick();
        end
        read_pc(v); chk("pre_rst_pc", v, 32'd3);
        iRF_AddrB = 4'd5; iRAS_en = 1'b1;
        tick();
        chk("pre_rst_r5", oMemData, 32'hFFFFFFDE);
        #2;
        nRst = 1'b0;
        #1;
        chk("async_rzl", oMemAddr, 32'd0);
        chk("async_ras", oMemData, 32'd0);
        iMUX_MAP = 1'b1;
        #1;
        chk("async_pc", oMemAddr, 32'd0);
        iMUX_MAP = 1'b0;
        @(negedge iClk);
        nRst = 1'b1;
        #1;
        sb_push("rst_r5", 32'd0); read_reg(4'd5, v); sb_check(v);
        sb_push("rst_r7", 32'd0); read_reg(4'd7, v); sb_check(v);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/minisrc_datapath.md
Name: minisrc_datapath

Overview:
- 32-bit MiniSRC processor datapath: program counter, 16x32 register file, ALU with operand/result latches, write-back register, and memory address/data paths.
- Contains no instruction decode. Every register enable, mux select and ALU opcode is driven each cycle by the external control unit.
- The immediate is supplied pre-extended by control on iImm32.

Parameters:
- None. Data width is fixed at 32 bits; register count is fixed at 16.

Ports:
- iClk in 1: system clock; all state updates on the rising edge.
- nRst in 1: asynchronous, active-low reset.
- iMemData in 32: memory read data.
- oMemAddr out 32: memory address.
- oMemData out 32: memory write data.
- iPC_nRst in 1: synchronous PC clear, active low.
- iPC_en in 1: PC update enable.
- iPC_jmp in 1: branch taken.
- iPC_loadRA in 1: load PC from RA.
- iPC_loadImm in 1: relative branch using the immediate.
- iRF_Write in 1: register file write enable.
- iRF_AddrA, iRF_AddrB, iRF_AddrC in 4 each: read port A, read port B, write port C.
- iRWB_en in 1: write-back register load.
- iALU_Ctrl in 4: ALU opcode.
- iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en in 1 each: latch enables.
- oJ_zero, oJ_nZero, oJ_pos, oJ_neg out 1 each: branch condition flags.
- oALU_neg, oALU_zero out 1 each: ALU low-word flags.
- iMUX_BIS, iMUX_RZHS, iMUX_WBM, iMUX_WBP, iMUX_MAP, iMUX_ASS in 1 each: mux selects.
- iImm32 in 32: extended immediate.

Behaviour:
- Reset: nRst low asynchronously clears PC, all 16 registers, RA, RB, RZH, RZL, RAS and RWB to 0. All outputs then evaluate from zeroed state.
- PC priority, evaluated at each rising edge:
  - iPC_nRst=0: PC<=0.
  - else iPC_en=1 and iPC_loadRA=1: PC<=RA.
  - else iPC_en=1, iPC_loadImm=1 and iPC_jmp=1: PC<=PC+1+iImm32.
  - else iPC_en=1: PC<=PC+1.
  - otherwise PC holds.
  - All PC arithmetic is modulo 2^32.
- Register file:
  - Reads on ports A and B are combinational.
  - Write on port C at the rising edge when iRF_Write=1; write data is RWB.
  - R0 is an ordinary register.
  - Read of an address written in the same cycle returns the old value.
- Operand latches:
  - RA<=port A when iRA_en=1.
  - RB<=(iMUX_BIS ? iImm32 : port B) when iRB_en=1.
- ALU (combinational, 64-bit result {hi,lo}; hi=0 unless noted):
  - 0 ADD, 1 SUB: lo=RA+RB or RA-RB, wrapping.
  - 2 AND, 3 OR.
  - 4 SHR (logical), 5 SHRA (arithmetic), 6 SHL, 7 ROR, 8 ROL: amount RB[4:0].
  - 9 MUL: signed 64-bit product RA*RB.
  - 10 DIV: signed; lo=quotient, hi=remainder. Divide by zero: lo=32'hFFFFFFFF, hi=RA.
  - 11 NEG: lo=-RA. 12 NOT: lo=~RA.
  - 13 PASSB: lo=RB. 14, 15: lo=0.
- Result latches: RZH<=hi when iRZH_en=1; RZL<=lo when iRZL_en=1.
- Flags (combinational, from current ALU lo):
  - oALU_zero = (lo==0).
  - oALU_neg = lo[31].
- Branch flags (combinational, from RA):
  - oJ_zero = (RA==0).
  - oJ_nZero = (RA!=0).
  - oJ_pos = ~RA[31] & (RA!=0).
  - oJ_neg = RA[31].
- Result path: ZOUT = iMUX_RZHS ? RZH : RZL.
- Store path:
  - RAS<=(iMUX_ASS ? ZOUT : port B) when iRAS_en=1.
  - oMemData = RAS.
- Write-back: RWB<= at the rising edge when iRWB_en=1, selected by priority:
  - iMUX_WBM=1: iMemData.
  - else iMUX_WBP=1: PC.
  - else ZOUT.
- Address: oMemAddr = iMUX_MAP ? PC : RZL (combinational).
- Latency: a register-to-register ALU op takes 4 edges: RA/RB load, RZ load, RWB load, RF write.

Optional Feature:
- Macro: DATAPATH_DIV_EN.
- Defined: DIV (opcode 10) is implemented as specified above.
- Undefined: no divider is synthesized, and opcode 10 yields hi=lo=0.

Test Plan:
- Load a register from memory:
  - iMemData=0x22, iMUX_WBM=1, iRWB_en=1 for one edge.
  - Then iRF_Write=1, AddrC=5.
  - Required: R5=0x22; R7 and R4 are loaded the same way with 0x24 and 0x28.
- NEG: AddrA=5 with RA load, opcode 11, RZL load, RWB load, write to R5 -> R5=0xFFFFFFDE, oALU_neg=1.
- Fetch:
  - iPC_nRst=1, iPC_en=1, iMUX_MAP=1 for one edge from reset.
  - Required: oMemAddr=0 before the edge; PC=1 after it.
  - Branch check: with iPC_loadImm=1, iPC_jmp=1, iImm32=4 -> PC=6.
- MUL: RA=0xFFFFFFFE, RB=3 via iMUX_BIS and iImm32 -> RZH=0xFFFFFFFF, RZL=0xFFFFFFFA.
- DIV:
  - RA=7, RB=2 -> lo=3, hi=1.
  - RB=0 -> lo=0xFFFFFFFF, hi=7.
  - Without DATAPATH_DIV_EN -> lo=0, hi=0.
- Reset mid-operation: assert nRst low while RZL=0x5 and PC=3 -> RZL, PC and all registers read 0 immediately, without waiting for a clock edge.
